// File: rtl/poly_coef_unpacker_if.sv
// poly_coef_unpacker_if: FIFO-side, coefficient-stream and control signals.
// master drives start/fifo_data/fifo_empty/coef_ready; slave is the unpacker.
interface poly_coef_unpacker_if #(
    parameter int IN_WIDTH   = 64,
    parameter int COEF_WIDTH = 13
);
    logic                  start;
    logic [IN_WIDTH-1:0]   fifo_data;
    logic                  fifo_empty;
    logic                  fifo_read_en;
    logic [COEF_WIDTH-1:0] coef_out;
    logic                  coef_valid;
    logic                  coef_ready;
    logic                  coef_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, fifo_data, fifo_empty, coef_ready,
        input  fifo_read_en, coef_out, coef_valid, coef_last, busy, done
    );

    modport slave (
        input  start, fifo_data, fifo_empty, coef_ready,
        output fifo_read_en, coef_out, coef_valid, coef_last, busy, done
    );
endinterface

// File: rtl/poly_coef_unpacker.sv
// poly_coef_unpacker: pops packed words from a FIFO and emits LSB-first
// COEF_WIDTH-bit coefficients, N_COEFFS per start pulse.
// Ports: clk, rst (async, active-high), bus (slave): start, fifo_data,
// fifo_empty, fifo_read_en, coef_out/valid/ready/last, busy, done.
module poly_coef_unpacker #(
    parameter int IN_WIDTH   = 64,
    parameter int COEF_WIDTH = 13,
    parameter int N_COEFFS   = 256
) (
    input  logic                clk,
    input  logic                rst,
    poly_coef_unpacker_if.slave bus
);
    localparam int ACC_W = IN_WIDTH + COEF_WIDTH - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int WORDS = N_COEFFS * COEF_WIDTH / IN_WIDTH;
    localparam int IDX_W = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
    localparam int WC_W  = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      coef_idx;
    logic [WC_W-1:0]       word_cnt;
    logic [COEF_WIDTH-1:0] coef_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;

    logic fetch;
    logic extract;
    logic hshake;

    // A fetch only happens while fewer than COEF_WIDTH bits remain, so
    // the widest acc content is COEF_WIDTH-1+IN_WIDTH = ACC_W bits.
    assign fetch = (state == RUN)
                && (bit_cnt < CNT_W'(COEF_WIDTH))
                && !bus.fifo_empty
                && (word_cnt < WC_W'(WORDS));

    assign extract = (state == RUN)
                  && (bit_cnt >= CNT_W'(COEF_WIDTH))
                  && (!valid_q || bus.coef_ready);

    assign hshake = valid_q && bus.coef_ready;

    assign bus.fifo_read_en = fetch;
    assign bus.coef_out     = coef_q;
    assign bus.coef_valid   = valid_q;
    assign bus.coef_last    = last_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            bit_cnt  <= '0;
            coef_idx <= '0;
            word_cnt <= '0;
            coef_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hshake && !extract) begin
                valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        busy_q   <= 1'b1;
                        acc      <= '0;
                        bit_cnt  <= '0;
                        coef_idx <= '0;
                        word_cnt <= '0;
                    end
                end
                RUN: begin
                    if (fetch) begin
                        // Head word is captured on the same edge that pops it.
                        acc      <= acc | (ACC_W'(bus.fifo_data) << bit_cnt);
                        bit_cnt  <= bit_cnt + CNT_W'(IN_WIDTH);
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                    if (extract) begin
                        coef_q   <= acc[COEF_WIDTH-1:0];
                        valid_q  <= 1'b1;
                        last_q   <= (coef_idx == IDX_W'(N_COEFFS - 1));
                        acc      <= acc >> COEF_WIDTH;
                        bit_cnt  <= bit_cnt - CNT_W'(COEF_WIDTH);
                        coef_idx <= coef_idx + IDX_W'(1);
                    end
                    // Total bits are word-aligned, so nothing is left over here.
                    if (hshake && last_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    acc     <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_coef_unpacker.sv
// tb_poly_coef_unpacker: scoreboard bench for 13-bit and 10-bit unpackers.
// FIFO model, stream monitor and per-feature test tasks.
module tb_poly_coef_unpacker;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    poly_coef_unpacker_if #(.IN_WIDTH(64), .COEF_WIDTH(13)) b13 ();
    poly_coef_unpacker_if #(.IN_WIDTH(64), .COEF_WIDTH(10)) b10 ();

    poly_coef_unpacker #(
        .IN_WIDTH(64), .COEF_WIDTH(13), .N_COEFFS(256)
    ) dut13 (
        .clk(clk), .rst(rst), .bus(b13.slave)
    );

    poly_coef_unpacker #(
        .IN_WIDTH(64), .COEF_WIDTH(10), .N_COEFFS(256)
    ) dut10 (
        .clk(clk), .rst(rst), .bus(b10.slave)
    );

    typedef struct packed {
        logic        last;
        logic [12:0] c;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] fq[$];
    exp_t        exq[$];
    logic [63:0] words[52];
    logic [12:0] got[256];
    int          nload = 0;
    int          pops13 = 0;
    bit          stall = 0;
    bit          rd_seen = 0;
    int          bits = 0;
    bit          pv = 0;
    bit          pr = 0;
    bit          prd = 0;
    bit          pl = 0;
    logic [12:0] pc = '0;

    function automatic void fdrive();
        b13.fifo_empty = stall || (fq.size() == 0);
        b13.fifo_data  = (fq.size() != 0) ? fq[0] : 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Pushes 52 words to the FIFO model and the 256 expected coefficients,
    // each taken bit by bit from the flat LSB-first word stream.
    task automatic load_poly(input bit fixed);
        exp_t e;
        int   p;
        nload  = 0;
        pops13 = 0;
        for (int i = 0; i < 52; i++) begin
            if (fixed && i == 0)
                words[i] = 64'hFEDC_BA98_7654_3210;
            else if (fixed && i == 1)
                words[i] = 64'h1;
            else
                words[i] = {$urandom, $urandom};
            fq.push_back(words[i]);
        end
        for (int i = 0; i < 256; i++) begin
            for (int b = 0; b < 13; b++) begin
                p = 13 * i + b;
                e.c[b] = words[p / 64][p % 64];
            end
            e.last = (i == 255);
            exq.push_back(e);
        end
        fdrive();
    endtask

    // FIFO pop: the DUT captured the head on the edge, advance it after.
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (fq.size() != 0) void'(fq.pop_front());
            pops13++;
        end
        fdrive();
    end

    // Stream monitor: tracks buffered bits, compares each newly loaded
    // coefficient with the scoreboard, checks hold-while-stalled.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   load;
        if (rst) begin
            bits = 0; pv = 0; pr = 0; prd = 0; pl = 0; pc = '0;
            rd_seen = 0;
        end else begin
            if (prd) bits += 64;
            load = b13.coef_valid && (!pv || pr);
            if (load) begin
                bits -= 13;
                checks++;
                if (exq.size() == 0) begin
                    errors++;
                    $display("FAIL stream: extra coef %h, none expected",
                             b13.coef_out);
                end else begin
                    e = exq.pop_front();
                    if ({b13.coef_last, b13.coef_out} !== e) begin
                        errors++;
                        $display("FAIL coef[%0d]: got %h last %b, exp %h last %b",
                                 nload, b13.coef_out, b13.coef_last, e.c, e.last);
                    end
                end
                if (nload < 256) got[nload] = b13.coef_out;
                nload++;
            end
            if (pv && !pr) begin
                checks++;
                if (b13.coef_valid !== 1'b1 || b13.coef_out !== pc
                    || b13.coef_last !== pl) begin
                    errors++;
                    $display("FAIL hold: got v%b %h l%b, exp v1 %h l%b",
                             b13.coef_valid, b13.coef_out, b13.coef_last, pc, pl);
                end
            end
            if (b13.fifo_read_en) begin
                checks++;
                if (b13.fifo_empty || bits >= 13) begin
                    errors++;
                    $display("FAIL pop: empty %b bits %0d, exp empty 0 bits<13",
                             b13.fifo_empty, bits);
                end
            end
            pv      = b13.coef_valid;
            pr      = b13.coef_ready;
            prd     = b13.fifo_read_en;
            pc      = b13.coef_out;
            pl      = b13.coef_last;
            rd_seen = prd;
        end
    end

    // Drives one polynomial to completion; reports done behaviour.
    task automatic drive_until_done(
        input  bit do_start,
        input  bit rnd_ready,
        input  int stall_at,
        input  int stall_len,
        input  int restart_at,
        output int dcyc,
        output bit busy_bad,
        output bit tmo,
        output bit valid_stall_end
    );
        bit seen = 0;
        dcyc = 0;
        busy_bad = 0;
        tmo = 1;
        valid_stall_end = 0;
        for (int k = 0; k < 4000; k++) begin
            b13.coef_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            b13.start = (do_start && k == 0) || (k == restart_at);
            stall = (k >= stall_at) && (k < stall_at + stall_len);
            fdrive();
            if (stall_len > 0 && k == stall_at + stall_len)
                valid_stall_end = b13.coef_valid;
            if (b13.done) begin
                dcyc++;
                if (b13.busy) busy_bad = 1;
                seen = 1;
            end else if (seen) begin
                tmo = 0;
                break;
            end
            step();
        end
        b13.start = 1'b0;
        b13.coef_ready = 1'b1;
        stall = 0;
        fdrive();
    endtask

    task automatic check_poly(input string nm, input int dcyc,
                              input bit busy_bad, input bit tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL %s timeout: no done pulse", nm);
        end
        checks++;
        if (nload !== 256 || pops13 !== 52 || exq.size() !== 0) begin
            errors++;
            $display("FAIL %s count: coefs %0d pops %0d left %0d, exp 256 52 0",
                     nm, nload, pops13, exq.size());
        end
        checks++;
        if (dcyc !== 1 || busy_bad) begin
            errors++;
            $display("FAIL %s done: width %0d busy_at_done %b, exp 1 0",
                     nm, dcyc, busy_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b13.start = 0; b13.coef_ready = 1; stall = 0; fdrive();
        b10.start = 0; b10.coef_ready = 1;
        b10.fifo_empty = 1; b10.fifo_data = '0;
        step();
        step();
        checks++;
        if ({b13.fifo_read_en, b13.coef_out, b13.coef_valid, b13.coef_last,
             b13.busy, b13.done} !== '0) begin
            errors++;
            $display("FAIL reset13: rd %b c %h v %b l %b busy %b done %b, exp all 0",
                     b13.fifo_read_en, b13.coef_out, b13.coef_valid,
                     b13.coef_last, b13.busy, b13.done);
        end
        checks++;
        if ({b10.fifo_read_en, b10.coef_out, b10.coef_valid, b10.coef_last,
             b10.busy, b10.done} !== '0) begin
            errors++;
            $display("FAIL reset10: rd %b c %h v %b l %b busy %b done %b, exp all 0",
                     b10.fifo_read_en, b10.coef_out, b10.coef_valid,
                     b10.coef_last, b10.busy, b10.done);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_boundary();
        int dcyc; bit bb; bit tmo; bit vs;
        load_poly(1);
        b13.coef_ready = 1;
        b13.start = 1;
        step();
        b13.start = 0;
        checks++;
        if (b13.busy !== 1'b1 || b13.fifo_read_en !== 1'b1) begin
            errors++;
            $display("FAIL first_run: busy %b rd %b, exp 1 1",
                     b13.busy, b13.fifo_read_en);
        end
        step();
        checks++;
        if (b13.coef_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_valid_early: got %b exp 0", b13.coef_valid);
        end
        step();
        checks++;
        if (b13.coef_valid !== 1'b1 || b13.coef_out !== 13'h1210) begin
            errors++;
            $display("FAIL first_coef: v %b c %h, exp 1 1210",
                     b13.coef_valid, b13.coef_out);
        end
        drive_until_done(0, 0, 9999, 0, -1, dcyc, bb, tmo, vs);
        checks++;
        if (got[1] !== 13'h12A1 || got[4] !== 13'h1FED) begin
            errors++;
            $display("FAIL boundary: c1 %h c4 %h, exp 12a1 1fed", got[1], got[4]);
        end
        check_poly("boundary", dcyc, bb, tmo);
    endtask

    task automatic test_ten();
        int n = 0; int p = 0; int dn = 0; int last_k = -1;
        b10.fifo_data = '1;
        b10.fifo_empty = 0;
        b10.coef_ready = 1;
        b10.start = 1;
        step();
        b10.start = 0;
        for (int k = 0; k < 1000; k++) begin
            if (b10.fifo_read_en) p++;
            if (b10.coef_valid) begin
                n++;
                checks++;
                if (b10.coef_out !== 10'h3FF || b10.coef_last !== (n == 256)) begin
                    errors++;
                    $display("FAIL ten coef[%0d]: %h last %b, exp 3ff last %b",
                             n - 1, b10.coef_out, b10.coef_last, (n == 256));
                end
                if (b10.coef_last) last_k = k;
            end
            if (b10.done) begin
                dn++;
                checks++;
                if (k != last_k + 1 || b10.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ten done_time: at %0d busy %b, exp %0d busy 0",
                             k, b10.busy, last_k + 1);
                end
            end else if (dn > 0) begin
                break;
            end
            step();
        end
        b10.fifo_empty = 1;
        checks++;
        if (n !== 256 || p !== 40 || dn !== 1) begin
            errors++;
            $display("FAIL ten count: coefs %0d pops %0d done %0d, exp 256 40 1",
                     n, p, dn);
        end
    endtask

    task automatic test_backpressure();
        int dcyc; bit bb; bit tmo; bit vs;
        load_poly(0);
        drive_until_done(1, 1, 9999, 0, -1, dcyc, bb, tmo, vs);
        check_poly("backpressure", dcyc, bb, tmo);
    endtask

    task automatic test_underrun();
        int dcyc; bit bb; bit tmo; bit vs;
        load_poly(0);
        drive_until_done(1, 0, 30, 20, -1, dcyc, bb, tmo, vs);
        checks++;
        if (vs !== 1'b0) begin
            errors++;
            $display("FAIL underrun drain: valid %b after stall, exp 0", vs);
        end
        check_poly("underrun", dcyc, bb, tmo);
    endtask

    task automatic test_start_in_run();
        int dcyc; bit bb; bit tmo; bit vs;
        load_poly(0);
        drive_until_done(1, 1, 9999, 0, 100, dcyc, bb, tmo, vs);
        check_poly("start_in_run", dcyc, bb, tmo);
    endtask

    task automatic test_reset_mid();
        int dcyc; bit bb; bit tmo; bit vs; bit hit = 0;
        load_poly(0);
        b13.coef_ready = 1;
        b13.start = 1;
        step();
        b13.start = 0;
        for (int k = 0; k < 1000; k++) begin
            if (nload >= 100) begin
                hit = 1;
                break;
            end
            step();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid reach: coefs %0d, exp 100", nload);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({b13.fifo_read_en, b13.coef_out, b13.coef_valid, b13.coef_last,
             b13.busy, b13.done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: rd %b c %h v %b l %b busy %b done %b, exp all 0",
                     b13.fifo_read_en, b13.coef_out, b13.coef_valid,
                     b13.coef_last, b13.busy, b13.done);
        end
        step();
        step();
        fq.delete();
        exq.delete();
        fdrive();
        rst = 1'b0;
        step();
        load_poly(0);
        drive_until_done(1, 0, 9999, 0, -1, dcyc, bb, tmo, vs);
        check_poly("reset_mid", dcyc, bb, tmo);
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_ten();
        test_backpressure();
        test_underrun();
        test_start_in_run();
        test_reset_mid();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_coef_unpacker.md
# poly_coef_unpacker

Consumes the 64-bit packed words that the polynomial input FIFO buffer holds and emits one unsigned coefficient per handshake, LSB-first, COEF_WIDTH bits each. It sits directly downstream of the FIFO buffer: it watches the FIFO's empty flag, pops with the FIFO's read enable, and feeds the NTT/arithmetic datapath over a valid/ready interface. One start pulse unpacks exactly one polynomial of N_COEFFS coefficients. It serves t1 (10 b), t0 (13 b), eta (3/4 b), z (18/20 b) encodings.

## Interface
- IN_WIDTH, 64: packed word width; must equal the FIFO's WIDTH.
- COEF_WIDTH, 13: coefficient width; legal range 1..24 and at most IN_WIDTH.
- N_COEFFS, 256: coefficients per polynomial; N_COEFFS*COEF_WIDTH must be a multiple of IN_WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a polynomial; honoured only in IDLE.
- fifo_data  in  IN_WIDTH  head word of the FIFO, valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  pop request; combinational from registered state and fifo_empty.
- coef_out  out  COEF_WIDTH  registered coefficient.
- coef_valid  out  1  coef_out holds an unconsumed coefficient.
- coef_ready  in  1  consumer accepts coef_out this cycle.
- coef_last  out  1  qualifies coef_out as coefficient N_COEFFS-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last coefficient is accepted.

## Operation
- Accumulator acc has ACC_W = IN_WIDTH+COEF_WIDTH-1 bits. bit_cnt counts valid bits in acc and has clog2(ACC_W+1) bits. coef_idx counts 0..N_COEFFS-1. word_cnt counts 0..WORDS-1, where WORDS = N_COEFFS*COEF_WIDTH/IN_WIDTH.
- States are IDLE, RUN and DONE.
- IDLE -> RUN on start. Entering RUN clears acc, bit_cnt, coef_idx and word_cnt.
- A fetch occurs in RUN when bit_cnt < COEF_WIDTH, fifo_empty=0 and word_cnt < WORDS:
  - fifo_read_en=1;
  - acc <= acc | (fifo_data << bit_cnt);
  - bit_cnt += IN_WIDTH;
  - word_cnt++.
- An extract occurs in RUN when bit_cnt >= COEF_WIDTH and (coef_valid=0 or coef_ready=1):
  - coef_out <= acc[COEF_WIDTH-1:0];
  - coef_valid <= 1;
  - coef_last <= (coef_idx == N_COEFFS-1);
  - acc >>= COEF_WIDTH;
  - bit_cnt -= COEF_WIDTH;
  - coef_idx++.
- Fetch and extract are mutually exclusive by construction.
- coef_valid clears on a handshake (valid and ready) when no new extract occurs in the same cycle.
- RUN -> DONE on a handshake with coef_last=1. Because total bits are word-aligned, bit_cnt is 0 at that point.
- DONE asserts done for one cycle, clears acc and bit_cnt, then returns to IDLE.
- fifo_read_en is never asserted outside RUN, and never when fifo_empty=1.
- start in RUN or DONE is ignored.

## Timing
- Reset values: fifo_read_en=0, coef_out=0, coef_valid=0, coef_last=0, busy=0, done=0, state=IDLE, all counters and acc = 0.
- Reset during RUN aborts immediately with no partial coefficient emitted. The FIFO is not flushed by this block.
- busy rises the cycle after start.
- The first fetch can occur in the first RUN cycle. The first coef_valid appears the cycle after that fetch.
- FIFO data is captured on the same edge that pops it, which relies on the FIFO's combinational head output.
- Throughput with coef_ready held high is one coefficient per cycle, plus one bubble per fetch. For 13 b that is 256+52 = 308 RUN cycles minimum.
- coef_out, coef_valid and coef_last hold stable while coef_valid=1 and coef_ready=0.
- done rises the cycle after the final handshake, for exactly one cycle. busy falls in that same cycle.
- A FIFO underrun (fifo_empty=1 when a fetch is needed) stalls RUN indefinitely with no error.

## Test plan
- COEF_WIDTH=13; word0=64'hFEDC_BA98_7654_3210, word1=64'h1 -> coef0=0x1210, coef1=0x12A1, coef4=0x1FED, which crosses the word boundary using word1 bit 0.
- COEF_WIDTH=10; 40 words of all-ones, coef_ready=1 -> 256 coefficients of 0x3FF, coef_last only on the 256th, done one cycle later, exactly 40 pops.
- COEF_WIDTH=13; coef_ready toggled randomly -> coef_out stable while stalled, no pop while bit_cnt>=13, sequence matches a reference model.
- fifo_empty held high for 20 cycles mid-polynomial -> fifo_read_en=0, coef_valid drops after the buffered bits are drained, and the stream resumes correctly.
- start pulsed during RUN -> ignored, coefficient count stays 256, single done pulse.
- rst asserted at coefficient 100 -> all outputs 0 immediately; a new start plus a fresh polynomial unpacks correctly from coefficient 0.
